uart_tx_arbiter: RTL and testbench

//   Shares one uart_tx serialiser (instantiated inside) between N_SRC byte-stream requesters.
//   - Grants are per message, not per byte: the owner keeps the line until it sends a byte with last=1.
//   - Owners are chosen round-robin.
//   - A watchdog releases an owner that stalls mid-message.
//   - Sits between message generators (banner/status printers) and the board TX pin.

---
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one
// 8N1 uart_tx serialiser between N_SRC byte-stream requesters.
module uart_tx #(
  parameter int CLOCKS_PER_BIT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);
  localparam int CW =
    (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] clk_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      shreg   <= '1;
      bit_cnt <= '0;
      clk_cnt <= '0;
    end else if (!busy) begin
      if (send) begin
        busy    <= 1'b1;
        shreg   <= {1'b1, data, 1'b0};
        bit_cnt <= '0;
        clk_cnt <= '0;
      end
    end else if (clk_cnt == CW'(CLOCKS_PER_BIT - 1)) begin
      clk_cnt <= '0;
      shreg   <= {1'b1, shreg[9:1]};
      if (bit_cnt == 4'd9) busy <= 1'b0;
      else bit_cnt <= bit_cnt + 4'd1;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  assign tx = busy ? shreg[0] : 1'b1;
endmodule

module uart_tx_arbiter #(
  parameter int N_SRC          = 4,
  parameter int CLOCKS_PER_BIT = 5,
  parameter int TIMEOUT        = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [N_SRC-1:0]   src_last,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]   src_ready,
  output logic [N_SRC-1:0]   grant,
  output logic               active,
  output logic               timeout,
  output logic               tx
);
  localparam int IW = $clog2(N_SRC);
  localparam int TW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE, LOAD, START, DRAIN
  } state_t;

  state_t           state, state_d;
  logic [IW-1:0]    owner, owner_d;
  logic [IW-1:0]    rr_ptr, rr_ptr_d;
  logic [IW-1:0]    pick, cand, next_ptr;
  logic [N_SRC-1:0] grant_d;
  logic [TW-1:0]    tmo_cnt, tmo_d;
  logic [IW+2:0]    off;
  logic [7:0]       data;
  logic             last_q, last_d;
  logic             timeout_d;
  logic             fire, busy;

  uart_tx #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_tx (
    .clk  (clk),
    .rst  (rst),
    .send (fire),
    .data (data),
    .busy (busy),
    .tx   (tx)
  );

  // Descending scan so the nearest index at/after rr_ptr wins.
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % N_SRC);
      if (src_valid[cand]) pick = cand;
    end
  end

  assign next_ptr = (owner == IW'(N_SRC - 1)) ?
                    '0 : owner + 1'b1;
  assign off       = {owner, 3'b000};
  assign data      = src_data[off +: 8];
  assign fire      = (state == LOAD) && src_valid[owner]
                     && !busy && !rst;
  assign src_ready = fire ? grant : '0;
  assign active    = |grant;

  always_comb begin
    state_d   = state;
    owner_d   = owner;
    grant_d   = grant;
    rr_ptr_d  = rr_ptr;
    last_d    = last_q;
    tmo_d     = tmo_cnt;
    timeout_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (|src_valid) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (fire) begin
          last_d  = src_last[owner];
          tmo_d   = '0;
          state_d = START;
        end else if (TIMEOUT != 0) begin
          if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            grant_d   = '0;
            rr_ptr_d  = next_ptr;
            tmo_d     = '0;
            timeout_d = 1'b1;
          end else begin
            tmo_d = tmo_cnt + 1'b1;
          end
        end
      end
      START: state_d = DRAIN;
      DRAIN: begin
        if (!busy) begin
          if (last_q) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      grant   <= '0;
      rr_ptr  <= '0;
      last_q  <= 1'b0;
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      owner   <= owner_d;
      grant   <= grant_d;
      rr_ptr  <= rr_ptr_d;
      last_q  <= last_d;
      tmo_cnt <= tmo_d;
      timeout <= timeout_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: message-level model, line decoder
// and directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int CPB = 5;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src_valid = '0;
  logic [3:0]  src_last  = '0;
  logic [31:0] src_data  = '0;
  logic [3:0]  src_ready, grant;
  logic        active, timeout, tx;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .N_SRC(N), .CLOCKS_PER_BIT(CPB), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_last(src_last),
    .src_data(src_data), .src_ready(src_ready),
    .grant(grant), .active(active),
    .timeout(timeout), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] src;
    logic       last;
    logic [7:0] b;
  } ent_t;

  ent_t       pend[$];
  logic [7:0] exp_q[$];
  int         line_log[$];
  int         grant_log[$];
  int         ten_log[$];
  int         acc_time[$];
  int         tmo_time[$];

  logic [3:0] acc_mask = '0;
  logic [3:0] prev_valid = '0;
  logic [3:0] prev_grant = '0;
  logic       rst_at_edge = 1'b1;
  logic       owner_last = 1'b0;
  int         m_rr = 0;
  int         tenure = 0;
  int         cyc = 0;
  int         dec_st = 0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = '0;

  task automatic chk(input string n, input int act,
                     input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, want);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [3:0] v,
                                 input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic int lb(input int i);
    return (i < line_log.size()) ? line_log[i] : -1;
  endfunction

  function automatic int gl(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  always @(posedge clk) rst_at_edge <= rst;

  // Requesters: pop on acceptance, present each source's head.
  initial forever begin
    logic [3:0]  v, l, seen;
    logic [31:0] d;
    @(posedge clk);
    #1;
    for (int s = 0; s < N; s++) begin
      if (acc_mask[s]) begin
        for (int k = 0; k < pend.size(); k++) begin
          if (int'(pend[k].src) == s) begin
            pend.delete(k);
            break;
          end
        end
      end
    end
    acc_mask = '0;
    v = '0; l = '0; d = '0; seen = '0;
    for (int k = 0; k < pend.size(); k++) begin
      if (!seen[pend[k].src]) begin
        seen[pend[k].src] = 1'b1;
        v[pend[k].src] = 1'b1;
        l[pend[k].src] = pend[k].last;
        d[pend[k].src*8 +: 8] = pend[k].b;
      end
    end
    src_valid = v;
    src_last  = l;
    src_data  = d;
  end

  // Per-cycle comparison against the message-level model.
  initial forever begin
    int g, k;
    @(negedge clk);
    cyc++;
    if (rst_at_edge) begin
      chk("rst_grant", grant, 0);
      chk("rst_ready", src_ready, 0);
      chk("rst_active", active, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_tx", tx, 1);
      m_rr = 0;
      exp_q.delete();
      dec_st = 0;
      tenure = 0;
      owner_last = 1'b0;
      prev_grant = '0;
    end else begin
      if (rst) chk("ready_in_rst", src_ready, 0);
      chk("grant_onehot", $onehot0(grant), 1);
      chk("active", active, grant != 0);
      chk("ready_owner", src_ready & ~grant, 0);
      chk("ready_onehot", $onehot0(src_ready), 1);
      chk("ready_valid", src_ready & ~src_valid, 0);
      if (prev_grant == 0 && grant != 0) begin
        chk("rr_pick", idx_of(grant),
            rr_pick(prev_valid, m_rr));
        grant_log.push_back(idx_of(grant));
        tenure = 0;
        owner_last = 1'b0;
      end else if (prev_grant != 0 && grant != 0) begin
        chk("grant_hold", grant, prev_grant);
      end
      if (prev_grant != 0 && grant == 0) begin
        chk("tmo_on_release", timeout, !owner_last);
        m_rr = (idx_of(prev_grant) + 1) % N;
        ten_log.push_back(tenure);
        if (timeout) tmo_time.push_back(cyc);
      end else begin
        chk("tmo_quiet", timeout, 0);
      end
      if (src_ready != 0) begin
        g = idx_of(src_ready);
        exp_q.push_back(src_data[g*8 +: 8]);
        owner_last = src_last[g];
        tenure++;
        acc_time.push_back(cyc);
      end
      if (dec_st == 0) begin
        if (tx == 1'b0) begin
          dec_st = 1;
          dec_cnt = 0;
        end
      end else begin
        dec_cnt++;
        if (dec_cnt == 2) chk("start_bit", tx, 0);
        if (dec_cnt >= CPB + 2 && (dec_cnt - 2) % CPB == 0) begin
          k = (dec_cnt - 2) / CPB;
          if (k <= 8) begin
            dec_byte[k-1] = tx;
          end else begin
            chk("stop_bit", tx, 1);
            line_log.push_back(dec_byte);
            chk("line_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
              chk("line_byte", dec_byte, exp_q.pop_front());
            dec_st = 0;
          end
        end
      end
    end
    prev_grant = grant;
    prev_valid = src_valid;
    acc_mask   = src_ready;
  end

  task automatic push(input int s, input logic [7:0] b,
                      input logic last);
    ent_t e;
    e.src  = s[1:0];
    e.last = last;
    e.b    = b;
    pend.push_back(e);
  endtask

  task automatic clear_logs();
    line_log.delete();
    grant_log.delete();
    ten_log.delete();
    acc_time.delete();
    tmo_time.delete();
  endtask

  task automatic wait_done(input string n);
    int i;
    for (i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (pend.size() == 0 && grant == 0 &&
          exp_q.size() == 0 && dec_st == 0) break;
    end
    if (i == 1500) begin
      total++;
      bad++;
      $display("FAIL %s: still busy after 1500 cycles", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    clear_logs();
    push(1, 8'h48, 1'b0);
    push(1, 8'h69, 1'b1);
    wait_done("t2_done");
    chk("t2_grants", grant_log.size(), 1);
    chk("t2_owner", gl(0), 1);
    chk("t2_b0", lb(0), 'h48);
    chk("t2_b1", lb(1), 'h69);
    chk("t2_nbytes", line_log.size(), 2);
    if (acc_time.size() == 2)
      chk("t2_gap", acc_time[1] - acc_time[0], 52);
    else chk("t2_accepts", acc_time.size(), 2);

    do_reset();
    clear_logs();
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0);
    push(2, 8'hC1, 1'b1);
    wait_done("t3_done");
    chk("t3_g0", gl(0), 0);
    chk("t3_g1", gl(1), 2);
    chk("t3_b0", lb(0), 'hA0);
    chk("t3_b1", lb(1), 'hA1);
    chk("t3_b2", lb(2), 'hC0);
    chk("t3_b3", lb(3), 'hC1);

    do_reset();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) push(s, 8'h40 + 8'(s), 1'b1);
    wait_done("t4_done");
    chk("t4_g0", gl(0), 0);
    chk("t4_g1", gl(1), 1);
    chk("t4_g2", gl(2), 2);
    chk("t4_g3", gl(3), 3);
    chk("t4_g4", gl(4), 0);
    chk("t4_g5", gl(5), 1);
    chk("t4_turns", ten_log.size(), 8);
    foreach (ten_log[i]) chk("t4_once", ten_log[i], 1);
    for (int i = 0; i < 8; i++)
      chk("t4_byte", lb(i), 'h40 + (i % N));

    clear_logs();
    push(3, 8'h55, 1'b0);
    wait_done("t5_done");
    chk("t5_owner", gl(0), 3);
    chk("t5_pulses", tmo_time.size(), 1);
    chk("t5_b0", lb(0), 'h55);
    if (tmo_time.size() == 1 && acc_time.size() == 1)
      chk("t5_delay", tmo_time[0] - acc_time[0], 72);
    clear_logs();
    push(2, 8'h2C, 1'b1);
    push(0, 8'h0C, 1'b1);
    wait_done("t5b_done");
    chk("t5_next0", gl(0), 0);
    chk("t5_next1", gl(1), 2);

    clear_logs();
    push(1, 8'h0F, 1'b1);
    for (int i = 0; i < 40 && dec_st == 0; i++)
      @(negedge clk);
    chk("t6_frame_started", dec_st, 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    clear_logs();
    push(3, 8'h33, 1'b1);
    push(0, 8'h30, 1'b1);
    wait_done("t6_done");
    chk("t6_g0", gl(0), 0);
    chk("t6_g1", gl(1), 3);
    chk("t6_b0", lb(0), 'h30);
    chk("t6_b1", lb(1), 'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
